// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: source-select encodings,
// FSM states and RISC-V load funct3 codes.
package wb_stage_pkg;

    localparam logic [1:0] SRC_RESULT  = 2'b00;
    localparam logic [1:0] SRC_DATAMEM = 2'b01;
    localparam logic [1:0] SRC_CSR     = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        DRAIN     = 2'd2
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shifts the naturally aligned memory word down
// to the addressed byte and sign/zero-extends according to the load type.
module load_align
    import wb_stage_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  raw,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;

    assign shifted = raw >> {offset, 3'b000};

    always_comb begin
        // NOTE: default assignment first so every path drives data and no latch is inferred.
        data = '0;
        case (funct3)
            F3_LB: begin
                data      = {XLEN{shifted[7]}};
                data[7:0] = shifted[7:0];
            end
            F3_LH: begin
                data       = {XLEN{shifted[15]}};
                data[15:0] = shifted[15:0];
            end
            F3_LW: begin
                data       = {XLEN{shifted[31]}};
                data[31:0] = shifted[31:0];
            end
            F3_LBU: data[7:0]  = shifted[7:0];
            F3_LHU: data[15:0] = shifted[15:0];
            F3_LD: begin
                if (XLEN == 64) data = shifted;
                else            data[31:0] = shifted[31:0];
            end
            // LWU and undefined encodings fall back to a zero-extended word.
            F3_LWU:  data[31:0] = shifted[31:0];
            default: data[31:0] = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the writeback source, waits for load responses,
// aligns load data, and produces a registered register-file write port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int RA_W  = 5,
    parameter  int CNT_W = 64,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       wb_src,
    input  logic [RA_W-1:0]  rd,
    input  logic [XLEN-1:0]  result,
    input  logic [XLEN-1:0]  csr_dataout,
    input  logic [2:0]       ld_funct3,
    input  logic [OFF_W-1:0] ld_offset,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             flush,
    output logic             wen,
    output logic [RA_W-1:0]  reg_addr,
    output logic [XLEN-1:0]  rdata,
    output logic             busy,
    output logic [CNT_W-1:0] instret
);

    wb_state_t        state, state_nxt;
    logic [RA_W-1:0]  cap_rd;
    logic             cap_we;
    logic [2:0]       cap_funct3;
    logic [OFF_W-1:0] cap_offset;

    logic             accept, is_load;
    logic [XLEN-1:0]  src_data, load_data;
    logic             wr_fire, wr_en;
    logic [RA_W-1:0]  wr_addr;
    logic [XLEN-1:0]  wr_data;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    // A flush in IDLE squashes whatever MEM is presenting this cycle.
    assign accept   = in_valid && in_ready && !flush;
    assign is_load  = (wb_src[1:0] == SRC_DATAMEM);

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3 (cap_funct3),
        .offset (cap_offset),
        .raw    (dmem_rdata),
        .data   (load_data)
    );

    always_comb begin
        case (wb_src[1:0])
            SRC_RESULT: src_data = result;
            SRC_CSR:    src_data = csr_dataout;
            default:    src_data = result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state avoid simulation races.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && is_load) state_nxt = WAIT_LOAD;
            WAIT_LOAD: begin
                if (dmem_rvalid) state_nxt = IDLE;
                else if (flush)  state_nxt = DRAIN;
            end
            DRAIN:     if (dmem_rvalid) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Write request for the coming edge; wr_fire marks a retiring instruction.
    always_comb begin
        wr_fire = 1'b0;
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_data = src_data;
        case (state)
            IDLE: if (accept && !is_load) begin
                wr_fire = 1'b1;
                wr_en   = wb_src[2] && (rd != '0);
            end
            WAIT_LOAD: if (dmem_rvalid && !flush) begin
                wr_fire = 1'b1;
                wr_en   = cap_we && (cap_rd != '0);
                wr_addr = cap_rd;
                wr_data = load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rd     <= '0;
            cap_we     <= 1'b0;
            cap_funct3 <= '0;
            cap_offset <= '0;
        end else if (accept && is_load) begin
            cap_rd     <= rd;
            cap_we     <= wb_src[2];
            cap_funct3 <= ld_funct3;
            cap_offset <= ld_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen      <= 1'b0;
            reg_addr <= '0;
            rdata    <= '0;
            instret  <= '0;
        end else begin
            wen <= wr_fire && wr_en;
            if (wr_fire && wr_en) begin
                reg_addr <= wr_addr;
                rdata    <= wr_data;
            end
            if (wr_fire) instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit and a 64-bit instance share control
// stimulus; expected values are hand-computed constants.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  wb_src;
    logic [4:0]  rd;
    logic [2:0]  ld_funct3;
    logic        dmem_rvalid;
    logic        flush;

    logic [31:0] result32, csr32, dmem32;
    logic [1:0]  off32;
    logic [63:0] result64, csr64, dmem64;
    logic [2:0]  off64;

    logic        in_ready32, wen32, busy32;
    logic [4:0]  reg_addr32;
    logic [31:0] rdata32;
    logic [63:0] instret32;

    logic        in_ready64, wen64, busy64;
    logic [4:0]  reg_addr64;
    logic [63:0] rdata64;
    logic [63:0] instret64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .wb_src(wb_src), .rd(rd), .result(result32), .csr_dataout(csr32),
        .ld_funct3(ld_funct3), .ld_offset(off32), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem32), .flush(flush), .wen(wen32), .reg_addr(reg_addr32),
        .rdata(rdata32), .busy(busy32), .instret(instret32)
    );

    wb_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .wb_src(wb_src), .rd(rd), .result(result64), .csr_dataout(csr64),
        .ld_funct3(ld_funct3), .ld_offset(off64), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem64), .flush(flush), .wen(wen64), .reg_addr(reg_addr64),
        .rdata(rdata64), .busy(busy64), .instret(instret64)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a load, then return its response in the first WAIT_LOAD cycle.
    task automatic do_load(input logic [4:0] r, input logic [2:0] f3,
                           input logic [1:0] o32, input logic [31:0] d32,
                           input logic [2:0] o64, input logic [63:0] d64);
        in_valid = 1'b1; wb_src = 3'b101; rd = r; ld_funct3 = f3;
        off32 = o32; off64 = o64;
        tick();
        in_valid = 1'b0; dmem_rvalid = 1'b1; dmem32 = d32; dmem64 = d64;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; wb_src = '0; rd = '0; ld_funct3 = '0;
        dmem_rvalid = 1'b0; flush = 1'b0;
        result32 = '0; csr32 = '0; dmem32 = '0; off32 = '0;
        result64 = '0; csr64 = '0; dmem64 = '0; off64 = '0;
        #12;
        check("rst_wen", wen32, 0);
        check("rst_addr", reg_addr32, 0);
        check("rst_rdata", rdata32, 0);
        check("rst_instret", instret32, 0);
        check("rst_ready", in_ready32, 1);
        check("rst_busy", busy32, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // RESULT write, one-cycle latency
        in_valid = 1'b1; wb_src = 3'b100; rd = 5'd5; result32 = 32'h1234;
        tick();
        check("res_wen", wen32, 1);
        check("res_addr", reg_addr32, 5);
        check("res_rdata", rdata32, 32'h1234);
        check("res_instret", instret32, 1);
        in_valid = 1'b0;
        tick();
        check("res_pulse", wen32, 0);
        check("res_hold_addr", reg_addr32, 5);
        check("res_hold_data", rdata32, 32'h1234);

        // CSR source
        in_valid = 1'b1; wb_src = 3'b110; rd = 5'd7; csr32 = 32'hCAFE_0001; result32 = 32'h1;
        tick();
        check("csr_rdata", rdata32, 32'hCAFE_0001);
        check("csr_instret", instret32, 2);

        // Reserved select behaves as RESULT
        wb_src = 3'b111; rd = 5'd8; result32 = 32'h55; csr32 = 32'h66;
        tick();
        check("rsv_rdata", rdata32, 32'h55);
        check("rsv_addr", reg_addr32, 8);
        check("rsv_instret", instret32, 3);

        // Write enable clear: retires without a write
        wb_src = 3'b000; rd = 5'd9; result32 = 32'h77;
        tick();
        check("nowe_wen", wen32, 0);
        check("nowe_addr_hold", reg_addr32, 8);
        check("nowe_instret", instret32, 4);

        // Flush in IDLE blocks acceptance
        wb_src = 3'b100; rd = 5'd3; flush = 1'b1;
        tick();
        check("fidle_wen", wen32, 0);
        check("fidle_instret", instret32, 4);
        check("fidle_ready", in_ready32, 1);
        in_valid = 1'b0; flush = 1'b0;

        // LB offset 3, response in the third WAIT_LOAD cycle; rvalid in accept cycle ignored
        in_valid = 1'b1; wb_src = 3'b101; rd = 5'd10; ld_funct3 = 3'b000; off32 = 2'd3;
        dmem_rvalid = 1'b1; dmem32 = 32'h1111_1111;
        tick();
        check("lb_accept_wen", wen32, 0);
        check("lb_wait1", in_ready32, 0);
        in_valid = 1'b0; dmem_rvalid = 1'b0;
        tick();
        check("lb_wait2", in_ready32, 0);
        tick();
        check("lb_wait3", in_ready32, 0);
        check("lb_busy", busy32, 1);
        dmem_rvalid = 1'b1; dmem32 = 32'h80FF_FF00;
        tick();
        dmem_rvalid = 1'b0;
        check("lb_wen", wen32, 1);
        check("lb_addr", reg_addr32, 10);
        check("lb_rdata", rdata32, 32'hFFFF_FF80);
        check("lb_ready", in_ready32, 1);
        check("lb_instret", instret32, 5);

        // LHU to x0: no write, still retires
        do_load(5'd0, 3'b101, 2'd2, 32'hBEEF_0000, 3'd0, 64'h0);
        check("lhu_x0_wen", wen32, 0);
        check("lhu_x0_rdata_hold", rdata32, 32'hFFFF_FF80);
        check("lhu_x0_instret", instret32, 6);

        do_load(5'd11, 3'b001, 2'd2, 32'hBEEF_0000, 3'd0, 64'h0);
        check("lh_rdata", rdata32, 32'hFFFF_BEEF);
        check("lh_instret", instret32, 7);

        do_load(5'd12, 3'b100, 2'd1, 32'h0000_9A00, 3'd0, 64'h0);
        check("lbu_rdata", rdata32, 32'h0000_009A);

        do_load(5'd13, 3'b111, 2'd1, 32'h8899_AABB, 3'd0, 64'h0);
        check("f3_111_rdata", rdata32, 32'h0088_99AA);
        check("f3_111_instret", instret32, 9);

        // Flush in WAIT_LOAD without a response: DRAIN, then discard
        in_valid = 1'b1; wb_src = 3'b101; rd = 5'd14; ld_funct3 = 3'b010; off32 = 2'd0;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        check("drain_busy", busy32, 1);
        check("drain_ready", in_ready32, 0);
        tick();
        flush = 1'b0;
        tick();
        check("drain_still", in_ready32, 0);
        dmem_rvalid = 1'b1; dmem32 = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        check("drain_wen", wen32, 0);
        check("drain_idle", in_ready32, 1);
        check("drain_instret", instret32, 9);
        check("drain_rdata_hold", rdata32, 32'h0088_99AA);

        // Flush coincident with the response
        in_valid = 1'b1; wb_src = 3'b101; rd = 5'd15;
        tick();
        in_valid = 1'b0; flush = 1'b1; dmem_rvalid = 1'b1; dmem32 = 32'h1234_5678;
        tick();
        flush = 1'b0; dmem_rvalid = 1'b0;
        check("fr_wen", wen32, 0);
        check("fr_idle", in_ready32, 1);
        check("fr_instret", instret32, 9);

        // Async reset mid-WAIT_LOAD, late response ignored
        in_valid = 1'b1; wb_src = 3'b101; rd = 5'd16;
        tick();
        in_valid = 1'b0;
        check("rstw_busy", busy32, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_addr", reg_addr32, 0);
        check("rstw_rdata", rdata32, 0);
        check("rstw_instret", instret32, 0);
        check("rstw_busy0", busy32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem32 = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        check("late_wen", wen32, 0);
        check("late_rdata", rdata32, 0);
        check("late_instret", instret32, 0);

        // 64-bit loads
        do_load(5'd17, 3'b010, 2'd0, 32'h0, 3'd4, 64'h8000_0001_DEAD_BEEF);
        check("lw64_wen", wen64, 1);
        check("lw64_addr", reg_addr64, 17);
        check("lw64_rdata", rdata64, 64'hFFFF_FFFF_8000_0001);
        check("lw64_instret", instret64, 1);

        do_load(5'd18, 3'b011, 2'd0, 32'hDEAD_BEEF, 3'd0, 64'h8000_0001_DEAD_BEEF);
        check("ld64_rdata", rdata64, 64'h8000_0001_DEAD_BEEF);
        check("ld32_undef_rdata", rdata32, 32'hDEAD_BEEF);

        do_load(5'd19, 3'b110, 2'd0, 32'h0, 3'd4, 64'h8000_0001_DEAD_BEEF);
        check("lwu64_rdata", rdata64, 64'h0000_0000_8000_0001);
        check("lwu64_instret", instret64, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
